aes_leak_monitor: RTL



---
 rtl/aes_leak_monitor.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/aes_leak_monitor.sv
// Divergence monitor for a golden/suspect AES core pair: aligns ciphertexts, compares aux buses, flags skew.
// Optional macro AES_LEAK_MON_SNAPSHOT_EN adds capture of the first offending operands.
module aes_leak_monitor #(
    parameter int DW       = 128,
    parameter int AW       = 32,
    parameter int DEPTH    = 4,
    parameter int MAX_SKEW = 16,
    parameter int CNTW     = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            arm_i,
    input  logic            clear_i,
    input  logic            gold_valid_i,
    input  logic [DW-1:0]   gold_data_i,
    input  logic            dut_valid_i,
    input  logic [DW-1:0]   dut_data_i,
    input  logic [AW-1:0]   gold_aux_i,
    input  logic [AW-1:0]   dut_aux_i,
    output logic            armed_o,
    output logic            alarm_o,
    output logic [1:0]      cause_o,
    output logic [31:0]     first_cycle_o,
    output logic [CNTW-1:0] mismatch_cnt_o,
    output logic [31:0]     pairs_o
`ifdef AES_LEAK_MON_SNAPSHOT_EN
    ,
    output logic [DW-1:0]   snap_gold_o,
    output logic [DW-1:0]   snap_dut_o,
    output logic [AW-1:0]   snap_gold_aux_o,
    output logic [AW-1:0]   snap_dut_aux_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(MAX_SKEW + 1);
    localparam logic [SW-1:0] SKEW_LAST = SW'(MAX_SKEW - 1);
    localparam logic [SW-1:0] SKEW_CAP  = SW'(MAX_SKEW);

    typedef enum logic [1:0] {IDLE, ARMED, ALARM} state_t;

    state_t        state;
    logic [DW-1:0] gold_mem [DEPTH];
    logic [DW-1:0] dut_mem  [DEPTH];
    logic [PW:0]   gold_wr, gold_rd, dut_wr, dut_rd;
    logic [SW-1:0] gold_age, dut_age;
    logic [31:0]   cyc;

    logic          active, pop;
    logic          gold_empty, dut_empty, gold_full, dut_full;
    logic          gold_push, dut_push, gold_ovf, dut_ovf;
    logic          gold_wait, dut_wait, gold_skew, dut_skew;
    logic          data_ev, aux_ev, skew_ev, any_ev;
    logic [1:0]    ev_cause;
    logic [DW-1:0] gold_head, dut_head;

    assign active     = (state != IDLE);
    assign gold_empty = (gold_wr == gold_rd);
    assign dut_empty  = (dut_wr == dut_rd);
    assign gold_full  = (gold_wr[PW] != gold_rd[PW]) && (gold_wr[PW-1:0] == gold_rd[PW-1:0]);
    assign dut_full   = (dut_wr[PW] != dut_rd[PW]) && (dut_wr[PW-1:0] == dut_rd[PW-1:0]);
    assign gold_head  = gold_mem[gold_rd[PW-1:0]];
    assign dut_head   = dut_mem[dut_rd[PW-1:0]];

    // A pop in the same cycle frees the head slot, so a push into a full FIFO is then not an overflow.
    assign pop       = active && !gold_empty && !dut_empty;
    assign gold_push = active && gold_valid_i && (!gold_full || pop);
    assign dut_push  = active && dut_valid_i && (!dut_full || pop);
    assign gold_ovf  = active && gold_valid_i && gold_full && !pop;
    assign dut_ovf   = active && dut_valid_i && dut_full && !pop;

    assign gold_wait = active && !gold_empty && dut_empty;
    assign dut_wait  = active && !dut_empty && gold_empty;
    assign gold_skew = gold_wait && (gold_age == SKEW_LAST);
    assign dut_skew  = dut_wait && (dut_age == SKEW_LAST);

    assign data_ev = pop && (gold_head != dut_head);
    assign aux_ev  = active && (gold_aux_i != dut_aux_i);
    assign skew_ev = gold_skew || dut_skew || gold_ovf || dut_ovf;
    assign any_ev  = data_ev || aux_ev || skew_ev;

    always_comb begin
        ev_cause = 2'd0;
        if (data_ev)      ev_cause = 2'd1;
        else if (aux_ev)  ev_cause = 2'd2;
        else if (skew_ev) ev_cause = 2'd3;
    end

    assign armed_o = (state != IDLE);
    assign alarm_o = (state == ALARM);

    // NOTE: storage arrays carry no reset; the pointers alone define emptiness, so stale words are never read.
    always_ff @(posedge clk_i) begin
        if (gold_push) gold_mem[gold_wr[PW-1:0]] <= gold_data_i;
        if (dut_push)  dut_mem[dut_wr[PW-1:0]]   <= dut_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || clear_i) begin
            state          <= IDLE;
            cause_o        <= '0;
            first_cycle_o  <= '0;
            mismatch_cnt_o <= '0;
            pairs_o        <= '0;
            cyc            <= '0;
            gold_wr        <= '0;
            gold_rd        <= '0;
            dut_wr         <= '0;
            dut_rd         <= '0;
            gold_age       <= '0;
            dut_age        <= '0;
        end else begin
            case (state)
                IDLE:    if (arm_i) state <= ARMED;
                ARMED: begin
                    if (any_ev) begin
                        state         <= ALARM;
                        cause_o       <= ev_cause;
                        first_cycle_o <= cyc;
                    end
                end
                ALARM:   state <= ALARM;
                default: state <= IDLE;
            endcase

            if (active && cyc != 32'hFFFF_FFFF) cyc <= cyc + 32'd1;

            if (gold_push) gold_wr <= gold_wr + 1'b1;
            if (dut_push)  dut_wr  <= dut_wr + 1'b1;
            if (pop) begin
                gold_rd <= gold_rd + 1'b1;
                dut_rd  <= dut_rd + 1'b1;
                if (pairs_o != 32'hFFFF_FFFF) pairs_o <= pairs_o + 32'd1;
                if (data_ev && !(&mismatch_cnt_o)) mismatch_cnt_o <= mismatch_cnt_o + 1'b1;
            end

            // Ages saturate at MAX_SKEW so a stuck head raises its skew event only once.
            if (!gold_wait)                  gold_age <= '0;
            else if (gold_age != SKEW_CAP)   gold_age <= gold_age + 1'b1;
            if (!dut_wait)                   dut_age  <= '0;
            else if (dut_age != SKEW_CAP)    dut_age  <= dut_age + 1'b1;
        end
    end

`ifdef AES_LEAK_MON_SNAPSHOT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || clear_i) begin
            snap_gold_o     <= '0;
            snap_dut_o      <= '0;
            snap_gold_aux_o <= '0;
            snap_dut_aux_o  <= '0;
        end else if (state == ARMED && any_ev) begin
            snap_gold_o     <= '0;
            snap_dut_o      <= '0;
            snap_gold_aux_o <= '0;
            snap_dut_aux_o  <= '0;
            if (data_ev) begin
                snap_gold_o <= gold_head;
                snap_dut_o  <= dut_head;
            end else if (aux_ev) begin
                snap_gold_aux_o <= gold_aux_i;
                snap_dut_aux_o  <= dut_aux_i;
            end else if (gold_skew || gold_ovf) begin
                snap_gold_o <= gold_head;
            end else begin
                snap_dut_o  <= dut_head;
            end
        end
    end
`endif

endmodule
